// File: rtl/fp32_pkg.sv
// Shared constants and stage payload types for the FP32 multiplier pipeline.
package fp32_pkg;

  localparam int unsigned FP_DATA_W    = 32;
  localparam int unsigned FP_EXP_W     = 8;
  localparam int unsigned FP_MAN_W     = 23;
  localparam int unsigned FP_SIG_W     = FP_MAN_W + 1;
  localparam int unsigned FP_PROD_W    = 2 * FP_SIG_W;
  localparam int unsigned S2_EXP_WIDTH = 10;
  localparam int unsigned EXP_BIAS     = 127;

  localparam logic [FP_EXP_W-1:0]  EXP_MAX = 8'hFF;
  localparam logic [FP_DATA_W-1:0] QNAN    = 32'h7FC0_0000;

  // Unpacked operands held in stage 1
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] ea;
    logic [FP_EXP_W-1:0] eb;
    logic [FP_SIG_W-1:0] ma;
    logic [FP_SIG_W-1:0] mb;
    logic                denorm;
  } s1_t;

  // Raw product and biased exponent held in stage 2
  typedef struct packed {
    logic                            sign;
    logic signed [S2_EXP_WIDTH-1:0]  expo;
    logic [FP_PROD_W-1:0]            prod;
    logic                            zero;
    logic                            inf;
  } s2_t;

  // Final packed result with classification flags
  typedef struct packed {
    logic [FP_DATA_W-1:0] result;
    logic                 zero;
    logic                 inf;
  } res_t;

endpackage

// File: rtl/normalize_round_floating_point32.sv
// Stage-3 combinational normalize, round and special-case select.
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the mantissa is truncated.
module normalize_round_floating_point32
  import fp32_pkg::*;
(
  input  s2_t  s2_i,
  output res_t res_o_c
);

  localparam logic signed [S2_EXP_WIDTH-1:0] EXP_OVF  = 10'sd255;
  localparam logic signed [S2_EXP_WIDTH-1:0] EXP_ZERO = 10'sd0;

  logic                           hi_c;
  logic [FP_MAN_W-1:0]            man_n_c;
  logic signed [S2_EXP_WIDTH-1:0] exp_n_c;
  logic [FP_MAN_W-1:0]            man_r_c;
  logic signed [S2_EXP_WIDTH-1:0] exp_r_c;

  assign hi_c = s2_i.prod[FP_PROD_W-1];

  // Align the product so the leading one becomes the hidden bit
  always_comb begin
    man_n_c = s2_i.prod[FP_PROD_W-3 -: FP_MAN_W];
    exp_n_c = s2_i.expo;
    if (hi_c) begin
      man_n_c = s2_i.prod[FP_PROD_W-2 -: FP_MAN_W];
      exp_n_c = s2_i.expo + S2_EXP_WIDTH'(1);
    end
  end

`ifdef ROUND_NEAREST_EN
  logic              guard_c;
  logic              sticky_c;
  logic              round_up_c;
  logic [FP_MAN_W:0] man_sum_c;

  // Round to nearest even; a carry out of the mantissa bumps the exponent
  always_comb begin
    guard_c    = hi_c ? s2_i.prod[FP_SIG_W-1] : s2_i.prod[FP_SIG_W-2];
    sticky_c   = hi_c ? (|s2_i.prod[FP_SIG_W-2:0]) : (|s2_i.prod[FP_SIG_W-3:0]);
    round_up_c = guard_c && (sticky_c || man_n_c[0]);
    man_sum_c  = {1'b0, man_n_c} + (FP_MAN_W+1)'(round_up_c);
    man_r_c    = man_sum_c[FP_MAN_W-1:0];
    exp_r_c    = exp_n_c + S2_EXP_WIDTH'(man_sum_c[FP_MAN_W]);
  end
`else
  logic unused_lsbs_c;

  // Truncation: discarded product bits play no part
  always_comb begin
    man_r_c = man_n_c;
    exp_r_c = exp_n_c;
  end
  assign unused_lsbs_c = ^s2_i.prod[FP_SIG_W-2:0];
`endif

  // Special operands first, then exponent range, then the normal encoding
  always_comb begin
    res_o_c = '0;
    if (s2_i.zero && s2_i.inf) begin
      res_o_c.result = QNAN;
      res_o_c.inf    = 1'b1;
    end else if (s2_i.inf) begin
      res_o_c.result = {s2_i.sign, EXP_MAX, 23'h0};
      res_o_c.inf    = 1'b1;
    end else if (s2_i.zero) begin
      res_o_c.result = {s2_i.sign, 31'h0};
      res_o_c.zero   = 1'b1;
    end else if (exp_r_c >= EXP_OVF) begin
      res_o_c.result = {s2_i.sign, EXP_MAX, 23'h0};
      res_o_c.inf    = 1'b1;
    end else if (exp_r_c <= EXP_ZERO) begin
      res_o_c.result = {s2_i.sign, 31'h0};
      res_o_c.zero   = 1'b1;
    end else begin
      res_o_c.result = {s2_i.sign, exp_r_c[FP_EXP_W-1:0], man_r_c};
    end
  end

endmodule

// File: rtl/multiplier_core_floating_point32.sv
// 3-stage pipelined FP32 multiplier with valid/ready handshake and global stall.
// ROUND_NEAREST_EN (in normalize_round_floating_point32) selects RNE instead of truncation.
module multiplier_core_floating_point32
  import fp32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MAN_WIDTH  = 23
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] inA,
  input  logic [DATA_WIDTH-1:0] inB,
  input  logic                  zero_flag,
  input  logic                  inf_flag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  res_zero,
  output logic                  res_inf
);

  logic adv_c;
  logic accept_c;

  logic s1_valid_q;
  logic s1_first_q;
  logic s1_zero_hold_q;
  logic s1_inf_hold_q;
  s1_t  s1_d;
  s1_t  s1_q;
  logic s1_zero_c;
  logic s1_inf_c;

  logic s2_valid_q;
  s2_t  s2_d;
  s2_t  s2_q;

  res_t res_c;
  logic out_valid_q;
  res_t out_q;

  assign adv_c    = !out_valid_q || out_ready;
  assign accept_c = in_valid && adv_c;
  assign in_ready = adv_c;

  // Unpack operands and add the hidden bit; a zero exponent forces the zero path
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = inA[DATA_WIDTH-1] ^ inB[DATA_WIDTH-1];
    s1_d.ea     = inA[DATA_WIDTH-2 -: EXP_WIDTH];
    s1_d.eb     = inB[DATA_WIDTH-2 -: EXP_WIDTH];
    s1_d.ma     = {1'b1, inA[MAN_WIDTH-1:0]};
    s1_d.mb     = {1'b1, inB[MAN_WIDTH-1:0]};
    s1_d.denorm = (s1_d.ea == '0) || (s1_d.eb == '0);
  end

  // Check-stage flags are live only in the first cycle after accept; later cycles use the copy
  assign s1_zero_c = s1_first_q ? zero_flag : s1_zero_hold_q;
  assign s1_inf_c  = s1_first_q ? inf_flag  : s1_inf_hold_q;

  // Stage 1 registers and check-stage flag capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q     <= 1'b0;
      s1_first_q     <= 1'b0;
      s1_zero_hold_q <= 1'b0;
      s1_inf_hold_q  <= 1'b0;
      s1_q           <= '0;
    end else begin
      s1_first_q <= accept_c;
      if (s1_first_q) begin
        s1_zero_hold_q <= zero_flag;
        s1_inf_hold_q  <= inf_flag;
      end
      if (adv_c) s1_valid_q <= in_valid;
      if (accept_c) s1_q <= s1_d;
    end
  end

  // Mantissa product and biased exponent sum
  always_comb begin
    s2_d      = '0;
    s2_d.sign = s1_q.sign;
    s2_d.expo = $signed(S2_EXP_WIDTH'(s1_q.ea)) + $signed(S2_EXP_WIDTH'(s1_q.eb))
              - $signed(S2_EXP_WIDTH'(EXP_BIAS));
    s2_d.prod = FP_PROD_W'(s1_q.ma) * FP_PROD_W'(s1_q.mb);
    s2_d.zero = s1_zero_c || s1_q.denorm;
    s2_d.inf  = s1_inf_c;
  end

  // Stage 2 registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (adv_c) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) s2_q <= s2_d;
    end
  end

  normalize_round_floating_point32 u_norm (
    .s2_i    (s2_q),
    .res_o_c (res_c)
  );

  // Output registers; frozen while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (adv_c) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) out_q <= res_c;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = out_q.result;
  assign res_zero  = out_q.zero;
  assign res_inf   = out_q.inf;

endmodule

// File: tb/tb_multiplier_core_floating_point32.sv
// Bench for multiplier_core_floating_point32: directed vectors, stall and reset
// scenarios, plus a short random burst, checked against an arithmetic reference model.
module tb_multiplier_core_floating_point32;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        zero_flag;
  logic        inf_flag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        res_zero;
  logic        res_inf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit lat_exact = 1'b1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        i;
    int          acc;
    bit          seen;
  } exp_t;
  exp_t sbq[$];

  multiplier_core_floating_point32 dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inA       (inA),
    .inB       (inB),
    .zero_flag (zero_flag),
    .inf_flag  (inf_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .res_zero  (res_zero),
    .res_inf   (res_inf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream check stage: flags registered one cycle after operands are presented
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      zero_flag <= 1'b0;
      inf_flag  <= 1'b0;
    end else begin
      zero_flag <= (inA[30:0] == 31'h0) || (inB[30:0] == 31'h0);
      inf_flag  <= (inA[30:23] == 8'hFF) || (inB[30:23] == 8'hFF);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: exact integer product, normalised and rounded by value, returns {zero, inf, result}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              ea, eb, e, sh;
    longint unsigned p, m, rem, half;
    bit              z, inf;
    s   = a[31] ^ b[31];
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    z   = (ea == 0) || (eb == 0);
    inf = (ea == 255) || (eb == 255);
    if (z && inf) return {2'b01, 32'h7FC00000};
    if (inf) return {2'b01, s, 8'hFF, 23'h0};
    if (z) return {2'b10, s, 31'h0};
    p   = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    sh  = (p >= (64'd1 << 47)) ? 24 : 23;
    e   = ea + eb - 127 + sh - 23;
    m   = p >> sh;
    rem = p - (m << sh);
    half = 64'd1 << (sh - 1);
`ifdef ROUND_NEAREST_EN
    if (rem > half || (rem == half && m[0])) m = m + 1;
`else
    if (rem > half) m = m + 0;
`endif
    if (m == (64'd1 << 24)) begin
      m = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'h0};
    if (e <= 0) return {2'b10, s, 31'h0};
    return {2'b00, s, 8'(e), m[22:0]};
  endfunction

  // Scoreboard: push on accept, compare every valid output cycle, pop on drain
  always @(negedge clk) begin
    logic [33:0] mv;
    exp_t        ent;
    int          lat;
    if (!rstn) begin
      sbq.delete();
    end else begin
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'h0);
        end else begin
          chk("sb_result", result, sbq[0].res);
          chk("sb_res_zero", 32'(res_zero), 32'(sbq[0].z));
          chk("sb_res_inf", 32'(res_inf), 32'(sbq[0].i));
          if (!sbq[0].seen) begin
            lat = cyc - sbq[0].acc;
            if (lat_exact) chk("sb_latency", 32'(lat), 32'd3);
            else chk("sb_latency_min", 32'(lat >= 3), 32'd1);
            sbq[0].seen = 1'b1;
          end
          if (out_ready) void'(sbq.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        mv       = model(inA, inB);
        ent.res  = mv[31:0];
        ent.z    = mv[33];
        ent.i    = mv[32];
        ent.acc  = cyc;
        ent.seen = 1'b0;
        sbq.push_back(ent);
      end
    end
  end

  // Single op with out_ready high: fixed latency and hand-computed result
  task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ei);
    int n;
    @(posedge clk); #1;
    inA = a; inB = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_valid"}, 32'(out_valid), 32'h1);
    chk({nm, "_latency"}, 32'(n + 1), 32'd3);
    chk({nm, "_result"}, result, er);
    chk({nm, "_zero"}, 32'(res_zero), 32'(ez));
    chk({nm, "_inf"}, 32'(res_inf), 32'(ei));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drained"}, 32'(sbq.size()), 32'h0);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:0] = 31'h0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: v[30:23] = 8'hFF;
      3: v[30:23] = 8'h00;
      default: v[30:23] = 8'($urandom_range(60, 190));
    endcase
    return v;
  endfunction

  initial begin
    int  issued;
    int  guard;
    bit  acc;
    logic [31:0] held;

    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    inA = 32'h0; inB = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_res_zero", 32'(res_zero), 32'h0);
    chk("rst_res_inf", 32'(res_inf), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    rstn = 1'b1;

    // Directed single operations
    run_one("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    run_one("neg_zero", 32'h80000000, 32'h40A00000, 32'h80000000, 1'b1, 1'b0);
    run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1);
    run_one("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b0, 1'b1);
    run_one("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 1'b0);
`ifdef ROUND_NEAREST_EN
    run_one("round", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0);
`else
    run_one("round", 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 1'b0, 1'b0);
`endif
    run_one("neg3x4", 32'hC0400000, 32'h40800000, 32'hC1400000, 1'b0, 1'b0);
    run_one("carry_1p5sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
    run_one("inf_x_one", 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b1);
    run_one("nan_x_one", 32'h7FC00000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b1);
    run_one("denorm", 32'h00400000, 32'h40000000, 32'h00000000, 1'b1, 1'b0);
    run_one("one_x_one", 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);

    // Back-to-back ops into a stalled consumer; a fourth op waits with different flags
    lat_exact = 1'b0;
    @(posedge clk); #1;
    inA = 32'h7F800000; inB = 32'h40000000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    inA = 32'h00000000; inB = 32'hC0000000;
    @(posedge clk); #1;
    inA = 32'h7F800000; inB = 32'hBF800000;
    @(posedge clk); #1;
    inA = 32'h3FC00000; inB = 32'h3FC00000;
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    held = result;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      chk("stall_out_valid", 32'(out_valid), 32'h1);
      chk("stall_hold", result, held);
    end
    chk("stall_head", result, 32'h7F800000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("stall");
    lat_exact = 1'b1;

    // Reset with two ops in flight discards them
    @(posedge clk); #1;
    inA = 32'h40000000; inB = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    inA = 32'h40400000; inB = 32'h40400000;
    @(posedge clk); #1;
    in_valid = 1'b0; rstn = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    end
    run_one("post_rst", 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);

    // Random burst with random back-pressure
    lat_exact = 1'b0;
    issued = 0;
    guard  = 0;
    while (issued < 40 && guard < 1000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) issued++;
      if (!in_valid || acc) begin
        if (issued < 40 && $urandom_range(0, 3) != 0) begin
          inA = rnd_fp(); inB = rnd_fp(); in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("rand_issued", 32'(issued), 32'd40);
    drain("rand");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
